sbox_share_scheduler: RTL and testbench
=======================================

# sbox_share_scheduler

Sequencer and round-robin arbiter that time-shares one masked, clock-gated Skinny 4-bit S-box instance (HPC2 gadgets, non-pipelined, `Synch`-signalled completion) among `NUM_REQ` requesters. It owns the S-box reset, holds the masked input shares and the fresh-randomness word stable for the whole evaluation, and waits for `Synch`. It then returns the masked output to the granted requester. It sits between the round datapath's nibble lanes and the S-box / PRNG.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `ORDER`, 1: masking order; share count `NS = ORDER+1`.
- `FRESH_W`, 17: fresh-randomness bits per evaluation.
- `LATENCY`, 9: S-box latency in cycles (its clock-gating count).
- `WDOG`, `LATENCY+4`: max RUN cycles before abort.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot accept.
- `req_x`  in  NUM_REQ*4*NS  requester r at `[r*4*NS +: 4*NS]`; share s at `[4s +: 4]`.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle pulse to owner.
- `rsp_err`  out  1  qualifies `rsp_valid`: evaluation aborted.
- `rsp_y`  out  4*NS  masked result, same share packing.
- `rnd_valid`  in  1  PRNG word available.
- `rnd_ready`  out  1  word consumed this cycle.
- `rnd_data`  in  FRESH_W  fresh randomness.
- `sbox_rst`  out  1  S-box / gating-controller reset.
- `sbox_x`  out  4*NS  S-box input shares.
- `sbox_fresh`  out  FRESH_W  S-box `Fresh`.
- `sbox_y`  in  4*NS  S-box output shares.
- `sbox_synch`  in  1  S-box `Synch`.
- `busy`  out  1  state ≠ IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  current/last owner.

## Operation
- FSM states: IDLE, RND, RUN, RESP.
- IDLE: `req_ready` is one-hot on the first valid requester at or after `rr_ptr`, cyclically. It is zero if there are no requests. On accept:
  - latch `req_x` into `x_q`;
  - set `grant_id`;
  - set `rr_ptr = grant_id+1` (wraps at NUM_REQ);
  - go to RND.
- RND: `rnd_ready=1`. On `rnd_valid`, latch `rnd_data` into `fresh_q` and go to RUN. The wait is unbounded.
- RUN:
  - `sbox_rst=0`;
  - clear the watchdog on entry, increment it each cycle;
  - on `sbox_synch`, latch `sbox_y` into `rsp_y` and go to RESP with `err=0`;
  - when the watchdog reaches `WDOG` without `sbox_synch`, go to RESP with `err=1` and leave `rsp_y` unchanged.
- RESP: `rsp_valid[grant_id]=1` for one cycle, `rsp_err=err`; go to IDLE.
- Outside RUN, `sbox_rst=1`. This guarantees a fresh latency count per evaluation.
- `sbox_x=x_q` and `sbox_fresh=fresh_q`, both constant from RUN entry to RUN exit.
- Each randomness word is used by exactly one evaluation and is never reused.
- Shares are never combined, XORed together or branched on. Requester data only passes through registers and muxes selected by `grant_id`.
- A `sbox_synch` seen outside RUN is ignored.
- Requesters deasserting `req_valid` before accept: no grant, no effect. `req_x` is not sampled after accept.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `grant_id=0`, `x_q=0`, `fresh_q=0`, `rsp_y=0`, `rsp_valid=0`, `rsp_err=0`, `rnd_ready=0`, `sbox_rst=1`, `busy=0`.
- Reset mid-operation: the evaluation is dropped and no `rsp_valid` is issued.
- Nominal schedule, with `rnd_valid` high and `sbox_synch` on the LATENCY-th RUN cycle:
  - accept at cycle 0;
  - `rnd_ready`/capture at 1;
  - RUN at cycles 2..10, with `sbox_synch` at 10;
  - `rsp_valid` at 11.
- Latency is `2+LATENCY+1` cycles plus any randomness stall.
- `req_ready` is combinational from state, `rr_ptr` and `req_valid`. All other outputs are registered or decoded from state.
- Throughput: one evaluation per `LATENCY+3` cycles.
- IDLE follows RESP, so no accept coincides with `rsp_valid`.

## Structure
- Package `sbox_sched_pkg` holds:
  - the state enum;
  - the `NS`/share-slice helper functions;
  - the default `LATENCY`/`FRESH_W` constants.
- Sub-module `rr_arbiter` (parameter `N`): inputs `req`, `ptr`; outputs one-hot `gnt`, `gnt_idx`, `any`. It is purely combinational.

## Test plan
- Single request, r=2, `req_x=8'hA5`, `rnd_valid` high, model S-box (LATENCY=9):
  - `sbox_rst` low cycles 2..10;
  - `sbox_fresh` stable;
  - `rsp_valid=4'b0100` at cycle 11, `rsp_err=0`, `rsp_y` equal to model output.
- All four requesters valid continuously: grants 0,1,2,3,0, each 12 cycles apart; no double grant.
- `rnd_valid` low for 5 cycles after accept:
  - RND held;
  - RUN starts the cycle after `rnd_valid` rises;
  - `rsp_valid` is delayed by exactly 5.
- Model never asserts `sbox_synch`: after 13 RUN cycles, `rsp_valid` to owner with `rsp_err=1`, then `sbox_rst=1`, then next request served normally.
- `rst` asserted at RUN cycle 4:
  - next cycle: IDLE, `sbox_rst=1`, `rr_ptr=0`;
  - no `rsp_valid` ever for the dropped request;
  - a subsequent r=3 request completes.
- Spurious `sbox_synch` in IDLE/RND: no state change, no response.

Source files
------------

// File: rtl/sbox_sched_pkg.sv
// Shared definitions for the masked S-box share scheduler.
//   - state_t         : scheduler FSM states
//   - DEFAULT_*       : default S-box latency and fresh-randomness width
//   - num_shares()    : share count for a given masking order
//   - req_lsb()       : LSB of requester r's share bundle inside the packed req_x bus
package sbox_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RND  = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int DEFAULT_LATENCY = 9;
    localparam int DEFAULT_FRESH_W = 17;

    function automatic int num_shares(input int order);
        return order + 1;
    endfunction

    // Each requester contributes 4*ns bits; share s of requester r sits at
    // req_lsb(r, ns) + 4*s.
    function automatic int req_lsb(input int r, input int ns);
        return r * 4 * ns;
    endfunction

endpackage

// File: rtl/sbox_share_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     [N]  request vector
//   ptr     [IW] highest-priority index this cycle (must be < N)
//   gnt     [N]  one-hot grant: first set bit of req at or after ptr, cyclically
//   gnt_idx [IW] binary index of the granted bit (0 when nothing is granted)
//   any          at least one request present
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        // Walk the ring starting at ptr; the first hit wins.
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sbox_share_scheduler.sv
// Time-shares one masked, non-pipelined S-box among NUM_REQ requesters.
// A request is accepted round-robin, one fresh-randomness word is fetched,
// the S-box is released from reset and its inputs are held constant until
// it signals sbox_synch (or the watchdog expires), then the masked result
// is returned to the owner with a one-cycle rsp_valid pulse.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/ready/x      requester side; req_ready is a one-hot accept
//   rsp_valid/err/y        response to the owner; rsp_err marks a watchdog abort
//   rnd_valid/ready/data   fresh-randomness source, one word per evaluation
//   sbox_rst/x/fresh       drive the shared S-box (held in reset outside RUN)
//   sbox_y/synch           S-box result shares and completion strobe
//   busy                   scheduler not idle
//   grant_id               current / last owner
module sbox_share_scheduler
    import sbox_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ORDER   = 1,
    parameter int FRESH_W = DEFAULT_FRESH_W,
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int WDOG    = LATENCY + 4,
    localparam int NS     = num_shares(ORDER),
    localparam int XW     = 4 * NS,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*XW-1:0] req_x,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic                  rsp_err,
    output logic [XW-1:0]         rsp_y,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    input  logic [FRESH_W-1:0]    rnd_data,
    output logic                  sbox_rst,
    output logic [XW-1:0]         sbox_x,
    output logic [FRESH_W-1:0]    sbox_fresh,
    input  logic [XW-1:0]         sbox_y,
    input  logic                  sbox_synch,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id
);

    localparam int WDW = $clog2(WDOG + 1);

    state_t             state_reg,    state_next;
    logic [IDW-1:0]     rr_ptr_reg,   rr_ptr_next;
    logic [IDW-1:0]     grant_id_reg, grant_id_next;
    logic [XW-1:0]      x_reg,        x_next;
    logic [FRESH_W-1:0] fresh_reg,    fresh_next;
    logic [XW-1:0]      rsp_y_reg,    rsp_y_next;
    logic               err_reg,      err_next;
    logic [WDW-1:0]     wdog_reg,     wdog_next;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDW-1:0]     arb_idx;
    logic               arb_any;

    // Per-requester share bundles, so the capture mux is a plain array select
    // on the arbiter index; shares are never combined.
    logic [XW-1:0] req_x_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_x_arr[gi] = req_x[req_lsb(gi, NS) +: XW];
            assign rsp_valid[gi] = (state_reg == ST_RESP) && (grant_id_reg == IDW'(gi));
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_reg),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            x_reg        <= '0;
            fresh_reg    <= '0;
            rsp_y_reg    <= '0;
            err_reg      <= 1'b0;
            wdog_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_id_reg <= grant_id_next;
            x_reg        <= x_next;
            fresh_reg    <= fresh_next;
            rsp_y_reg    <= rsp_y_next;
            err_reg      <= err_next;
            wdog_reg     <= wdog_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_id_next = grant_id_reg;
        x_next        = x_reg;
        fresh_next    = fresh_reg;
        rsp_y_next    = rsp_y_reg;
        err_next      = err_reg;
        wdog_next     = wdog_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_id_next = arb_idx;
                    x_next        = req_x_arr[arb_idx];
                    rr_ptr_next   = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + IDW'(1);
                    state_next    = ST_RND;
                end
            end
            ST_RND: begin
                // Watchdog is cleared here so it reads zero on the first RUN cycle.
                if (rnd_valid) begin
                    fresh_next = rnd_data;
                    wdog_next  = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sbox_synch) begin
                    rsp_y_next = sbox_y;
                    err_next   = 1'b0;
                    state_next = ST_RESP;
                end else if (wdog_reg == WDW'(WDOG - 1)) begin
                    // WDOG RUN cycles elapsed without completion; rsp_y keeps
                    // its previous value.
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    wdog_next = wdog_reg + WDW'(1);
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_reg == ST_IDLE) ? arb_gnt : '0;
    assign rnd_ready  = (state_reg == ST_RND);
    // Holding the S-box in reset outside RUN restarts its latency count for
    // every evaluation.
    assign sbox_rst   = (state_reg != ST_RUN);
    assign busy       = (state_reg != ST_IDLE);
    assign rsp_err    = (state_reg == ST_RESP) && err_reg;
    assign rsp_y      = rsp_y_reg;
    assign grant_id   = grant_id_reg;
    assign sbox_x     = x_reg;
    assign sbox_fresh = fresh_reg;

endmodule

// File: tb/tb_sbox_share_scheduler.sv
// Scoreboard bench for sbox_share_scheduler with a behavioural masked S-box.
module tb_sbox_share_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ORDER   = 1;
    localparam int NS      = ORDER + 1;
    localparam int XW      = 4 * NS;
    localparam int FRESH_W = 17;
    localparam int LATENCY = 9;
    localparam int WDOG    = LATENCY + 4;
    localparam int IDW     = 2;
    localparam int NFRESH  = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*XW-1:0] req_x;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic                  rsp_err;
    logic [XW-1:0]         rsp_y;
    logic                  rnd_valid;
    logic                  rnd_ready;
    logic [FRESH_W-1:0]    rnd_data;
    logic                  sbox_rst;
    logic [XW-1:0]         sbox_x;
    logic [FRESH_W-1:0]    sbox_fresh;
    logic [XW-1:0]         sbox_y;
    logic                  sbox_synch;
    logic                  busy;
    logic [IDW-1:0]        grant_id;

    sbox_share_scheduler #(
        .NUM_REQ (NUM_REQ),
        .ORDER   (ORDER),
        .FRESH_W (FRESH_W),
        .LATENCY (LATENCY),
        .WDOG    (WDOG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_y      (rsp_y),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .sbox_rst   (sbox_rst),
        .sbox_x     (sbox_x),
        .sbox_fresh (sbox_fresh),
        .sbox_y     (sbox_y),
        .sbox_synch (sbox_synch),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    // ---------------- reference functions ----------------
    function automatic logic [3:0] skinny4(input logic [3:0] v);
        case (v)
            4'h0: skinny4 = 4'hc; 4'h1: skinny4 = 4'h6; 4'h2: skinny4 = 4'h9; 4'h3: skinny4 = 4'h0;
            4'h4: skinny4 = 4'h1; 4'h5: skinny4 = 4'ha; 4'h6: skinny4 = 4'h2; 4'h7: skinny4 = 4'hb;
            4'h8: skinny4 = 4'h3; 4'h9: skinny4 = 4'h8; 4'ha: skinny4 = 4'h5; 4'hb: skinny4 = 4'hd;
            4'hc: skinny4 = 4'h4; 4'hd: skinny4 = 4'he; 4'he: skinny4 = 4'h7; default: skinny4 = 4'hf;
        endcase
    endfunction

    // Masked S-box: unmask, substitute, remask with masks taken from fresh.
    function automatic logic [XW-1:0] sbox_ref(input logic [XW-1:0] x, input logic [FRESH_W-1:0] f);
        logic [3:0]    v, m, acc;
        logic [XW-1:0] y;
        v = '0;
        for (int s = 0; s < NS; s++) v ^= x[4*s +: 4];
        y   = '0;
        acc = '0;
        for (int i = 1; i < NS; i++) begin
            m          = f[4*i-4 +: 4] ^ f[FRESH_W-4*i +: 4];
            y[4*i +: 4] = m;
            acc        ^= m;
        end
        y[3:0] = skinny4(v) ^ acc;
        return y;
    endfunction

    // ---------------- environment ----------------
    logic [NUM_REQ-1:0] want;
    logic [XW-1:0]      x_arr [NUM_REQ];
    logic [FRESH_W-1:0] fresh_seq [NFRESH];
    int                 rnd_idx;
    logic               rnd_en;
    logic               spur;
    logic               hang;
    int                 sb_cnt;
    int                 cyc;

    assign req_valid = want;
    assign rnd_valid = rnd_en;
    assign rnd_data  = fresh_seq[rnd_idx % NFRESH];

    always_comb begin
        req_x = '0;
        for (int r = 0; r < NUM_REQ; r++) req_x[r*XW +: XW] = x_arr[r];
    end

    // Model S-box: counts cycles out of reset, completes on the LATENCY-th.
    always @(posedge clk) begin
        if (sbox_rst) sb_cnt <= 0;
        else          sb_cnt <= sb_cnt + 1;
        cyc <= cyc + 1;
    end
    assign sbox_synch = spur | (!sbox_rst && !hang && sb_cnt == LATENCY - 1);
    assign sbox_y     = sbox_ref(sbox_x, sbox_fresh);

    // ---------------- scoreboard ----------------
    typedef struct {
        int            owner;
        bit            err;
        logic [XW-1:0] y;
        int            lat;
    } exp_t;

    exp_t        sb_q [$];
    string       name_q [$];
    logic [63:0] act_q [$];
    logic [63:0] exp_q [$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          acc_cyc [NUM_REQ];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        name_q.push_back(nm);
        act_q.push_back(act);
        exp_q.push_back(exp);
    endtask

    task automatic push_rsp(input int owner, input bit err, input logic [XW-1:0] y, input int lat);
        exp_t e;
        e.owner = owner;
        e.err   = err;
        e.y     = y;
        e.lat   = lat;
        sb_q.push_back(e);
    endtask

    // Monitor: samples 2 time units after the falling edge.
    always @(negedge clk) begin
        exp_t               e;
        logic [NUM_REQ-1:0] ev;
        int                 lat;
        string              nm;
        logic [63:0]        a, x;
        #2;
        if (req_ready != '0) begin
            n_vec++;
            if (!$onehot(req_ready) || ((req_ready & ~req_valid) != '0)) begin
                n_fail++;
                $display("FAIL accept_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
            end
            for (int r = 0; r < NUM_REQ; r++) if (req_ready[r]) acc_cyc[r] = cyc;
        end
        if (rsp_valid != '0) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=%b rsp_err=%b rsp_y=%h, none expected",
                         rsp_valid, rsp_err, rsp_y);
            end else begin
                e = sb_q.pop_front();
                ev = '0;
                ev[e.owner] = 1'b1;
                lat = cyc - acc_cyc[e.owner];
                $display("rsp owner=%0d err=%b y=%h lat=%0d", e.owner, rsp_err, rsp_y, lat);
                if (rsp_valid != ev || rsp_err != e.err || rsp_y != e.y || (e.lat >= 0 && lat != e.lat)) begin
                    n_fail++;
                    $display("FAIL rsp: got valid=%b err=%b y=%h lat=%0d, want valid=%b err=%b y=%h lat=%0d",
                             rsp_valid, rsp_err, rsp_y, lat, ev, e.err, e.y, e.lat);
                end
            end
        end
        while (name_q.size() > 0) begin
            nm = name_q.pop_front();
            a  = act_q.pop_front();
            x  = exp_q.pop_front();
            n_vec++;
            if (a !== x) begin
                n_fail++;
                $display("FAIL %s: got %0h, want %0h", nm, a, x);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic               hold;
    logic               rnd_rand;
    logic               spacing_on;
    logic [NUM_REQ-1:0] last_rdy;
    int                 tcyc;
    int                 prev_acc;
    int                 fresh_k;
    int                 ptr_model;
    logic [XW-1:0]      last_y;

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick();
        logic rv;
        #1;
        last_rdy = req_ready;
        rv       = rnd_valid & rnd_ready;
        if (last_rdy != '0) begin
            if (spacing_on && prev_acc >= 0) chk("grant_spacing", 64'(tcyc - prev_acc), 64'(LATENCY + 3));
            prev_acc = tcyc;
        end
        @(posedge clk);
        #1;
        if (rv) rnd_idx++;
        if (!hold) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (last_rdy[r]) begin
                    want[r]  = 1'b0;
                    x_arr[r] = XW'($urandom);
                end
            end
        end
        if (rnd_rand) rnd_en = ($urandom_range(0, 2) != 0);
        tcyc++;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((want != '0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("idle_timeout", 64'(1), 64'(0));
    endtask

    // Reference round-robin: all of mask is presented at once and held.
    task automatic predict_batch(input logic [NUM_REQ-1:0] mask, input int lat);
        logic [NUM_REQ-1:0] pend;
        int                 r;
        logic [XW-1:0]      y;
        pend = mask;
        while (pend != '0) begin
            r = -1;
            for (int k = 0; k < NUM_REQ; k++)
                if (r < 0 && pend[(ptr_model + k) % NUM_REQ]) r = (ptr_model + k) % NUM_REQ;
            y = sbox_ref(x_arr[r], fresh_seq[fresh_k % NFRESH]);
            push_rsp(r, 1'b0, y, lat);
            last_y    = y;
            fresh_k++;
            ptr_model = (r + 1) % NUM_REQ;
            pend[r]   = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int            acc_n, n, kk;
        logic [NUM_REQ-1:0] mask;
        logic [FRESH_W-1:0] f_used;
        rst = 1'b1; want = '0; rnd_en = 1'b1; spur = 1'b0; hang = 1'b0;
        hold = 1'b0; rnd_rand = 1'b0; spacing_on = 1'b0; rnd_idx = 0; cyc = 0; tcyc = 0;
        prev_acc = -1; fresh_k = 0; ptr_model = 0; last_y = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            x_arr[r]   = XW'($urandom);
            acc_cyc[r] = 0;
        end
        for (int i = 0; i < NFRESH; i++) fresh_seq[i] = FRESH_W'($urandom);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sbox_rst", 64'(sbox_rst), 64'(1));
        chk("rst_rnd_ready", 64'(rnd_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_rsp_y", 64'(rsp_y), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_sbox_x", 64'(sbox_x), 64'(0));
        chk("rst_sbox_fresh", 64'(sbox_fresh), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        tick();

        // All four requesters held valid: grants 0,1,2,3,0, 12 cycles apart
        for (int i = 0; i < 5; i++) begin
            push_rsp(ptr_model, 1'b0, sbox_ref(x_arr[ptr_model], fresh_seq[fresh_k]), LATENCY + 2);
            last_y    = sbox_ref(x_arr[ptr_model], fresh_seq[fresh_k]);
            fresh_k++;
            ptr_model = (ptr_model + 1) % NUM_REQ;
        end
        hold = 1'b1; spacing_on = 1'b1; prev_acc = -1;
        want = '1;
        acc_n = 0; n = 0;
        while (acc_n < 5 && n < 200) begin
            tick();
            if (last_rdy != '0) acc_n++;
            n++;
        end
        if (n >= 200) chk("cont_timeout", 64'(1), 64'(0));
        want = '0; hold = 1'b0; spacing_on = 1'b0;
        wait_idle(100);

        // Single request r=2, x=A5, nominal schedule
        x_arr[2] = 8'hA5;
        predict_batch(4'b0100, LATENCY + 2);
        kk = fresh_k - 1;
        f_used = fresh_seq[kk % NFRESH];
        want = 4'b0100;
        #1;
        chk("t1_req_ready", 64'(req_ready), 64'(4'b0100));
        tick();
        chk("t1_rnd_ready", 64'(rnd_ready), 64'(1));
        chk("t1_sbox_rst_rnd", 64'(sbox_rst), 64'(1));
        chk("t1_grant_id", 64'(grant_id), 64'(2));
        for (int c = 2; c <= 10; c++) begin
            tick();
            chk("t1_sbox_rst_run", 64'(sbox_rst), 64'(0));
            chk("t1_sbox_fresh", 64'(sbox_fresh), 64'(f_used));
            chk("t1_sbox_x", 64'(sbox_x), 64'(8'hA5));
        end
        tick();
        chk("t1_sbox_rst_resp", 64'(sbox_rst), 64'(1));
        tick();
        chk("t1_idle", 64'(busy), 64'(0));

        // Randomness stall of 5 cycles with a spurious synch during RND
        predict_batch(4'b0010, LATENCY + 2 + 5);
        rnd_en = 1'b0;
        want = 4'b0010;
        tick();
        for (int c = 1; c <= 5; c++) begin
            chk("stall_rnd_ready", 64'(rnd_ready), 64'(1));
            chk("stall_sbox_rst", 64'(sbox_rst), 64'(1));
            spur = (c == 3);
            tick();
        end
        spur = 1'b0;
        rnd_en = 1'b1;
        chk("stall_rnd_ready_last", 64'(rnd_ready), 64'(1));
        tick();
        chk("stall_run_start", 64'(sbox_rst), 64'(0));
        wait_idle(60);

        // Spurious synch while idle
        spur = 1'b1;
        tick();
        chk("spur_idle_busy", 64'(busy), 64'(0));
        tick();
        chk("spur_idle_busy2", 64'(busy), 64'(0));
        spur = 1'b0;

        // S-box never completes: watchdog abort after WDOG RUN cycles
        hang = 1'b1;
        push_rsp(0, 1'b1, last_y, WDOG + 2);
        fresh_k++;
        ptr_model = 1;
        want = 4'b0001;
        for (int c = 1; c <= WDOG + 1; c++) tick();
        chk("wdog_last_run", 64'(sbox_rst), 64'(0));
        tick();
        tick();
        chk("wdog_sbox_rst_after", 64'(sbox_rst), 64'(1));
        chk("wdog_idle", 64'(busy), 64'(0));
        hang = 1'b0;
        predict_batch(4'b0100, LATENCY + 2);
        want = 4'b0100;
        wait_idle(60);

        // Reset at RUN cycle 4: evaluation dropped, pointer back to 0
        want = 4'b0010;
        fresh_k++;
        for (int c = 1; c <= 5; c++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_sbox_rst", 64'(sbox_rst), 64'(1));
        chk("midrst_rsp_y", 64'(rsp_y), 64'(0));
        rst = 1'b0;
        ptr_model = 0;
        last_y = '0;
        repeat (4) tick();
        predict_batch(4'b1010, LATENCY + 2);
        want = 4'b1010;
        wait_idle(80);

        // Randomized batches with random randomness stalls
        for (int b = 0; b < 8; b++) begin
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int r = 0; r < NUM_REQ; r++) if (mask[r]) x_arr[r] = XW'($urandom);
            predict_batch(mask, -1);
            rnd_rand = 1'b1;
            want = mask;
            wait_idle(600);
            rnd_rand = 1'b0;
            rnd_en = 1'b1;
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        chk("fresh_words_used", 64'(rnd_idx), 64'(fresh_k));
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
